// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state and next-PC source types for the PC sequencer
package pc_seq_pkg;
  typedef enum logic {RUN, HALTED} pc_state_t;
  typedef enum logic [2:0] {SRC_SEQ, SRC_BR, SRC_JMP, SRC_CALL, SRC_RET} pc_src_t;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of return addresses; a push while full overwrites the oldest entry
module return_addr_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW:0] count_q;
  logic overflow_q, underflow_q, full;
  assign full = count_q == (PW+1)'(DEPTH);
  assign top = mem_q[ptr_q - PW'(1)];
  assign count = count_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  // storage write; ptr_q always names the slot after the newest entry, which is the oldest one when full
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end
  // pointer, occupancy and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q <= push && full;
      underflow_q <= pop && count_q == '0;
      if (push) begin
        ptr_q <= ptr_q + PW'(1);
        if (!full) count_q <= count_q + 1'b1;
      end else if (pop && count_q != '0) begin
        ptr_q <= ptr_q - PW'(1);
        count_q <= count_q - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address register with prioritised next-PC select, return stack and RUN/HALTED control
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          ADDR_W = 5,
  parameter int unsigned STEP = 1,
  parameter int unsigned RESET_ADDR = 0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_target,
  input  logic                       jump,
  input  logic                       call,
  input  logic [ADDR_W-1:0]          jump_target,
  input  logic                       ret,
  input  logic                       halt,
  input  logic                       resume,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_plus,
  output logic                       halted,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);
  pc_state_t state_q, state_d;
  pc_src_t src;
  logic [ADDR_W-1:0] pc_q, pc_d, ras_top;
  logic active, push, pop;
  assign pc = pc_q;
  assign pc_plus = pc_q + ADDR_W'(STEP);
  assign halted = state_q == HALTED;
  // state and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= ADDR_W'(RESET_ADDR);
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  // next state, next-PC select and stack control; halt in RUN suppresses every redirect
  always_comb begin
    active = state_q == RUN && !halt;
    src = ret ? SRC_RET : call ? SRC_CALL : jump ? SRC_JMP : branch_taken ? SRC_BR : SRC_SEQ;
    pop = active && src == SRC_RET;
    push = active && src == SRC_CALL;
    state_d = state_q == RUN ? (halt ? HALTED : RUN) : (resume && !halt ? RUN : HALTED);
    pc_d = !(active && (enable || src != SRC_SEQ)) ? pc_q :
           src == SRC_RET ? (ras_count != '0 ? ras_top : pc_plus) :
           (src == SRC_CALL || src == SRC_JMP) ? jump_target :
           src == SRC_BR ? branch_target : pc_plus;
  end
  return_addr_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .push_data(pc_plus),
    .top(ras_top),
    .count(ras_count),
    .overflow(ras_overflow),
    .underflow(ras_underflow)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table plus randomized run against a queue-based reference model
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset, enable, branch_taken, jump, call, ret, halt, resume;
  logic [4:0] branch_target, jump_target, pc, pc_plus;
  logic halted, ras_overflow, ras_underflow;
  logic [2:0] ras_count;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pc_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .call(call), .jump_target(jump_target),
    .ret(ret), .halt(halt), .resume(resume), .pc(pc), .pc_plus(pc_plus), .halted(halted),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );
  typedef struct {
    bit rst, en, br; int bt; bit jmp, cl; int jt; bit rt, hl, rs;
    int pc, cnt; bit h, ov, un;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(bit rst, bit en, bit br, int bt, bit jmp, bit cl, int jt, bit rt, bit hl, bit rs,
                             int epc, int cnt, bit h, bit ov, bit un);
    vec_t r;
    r.rst = rst; r.en = en; r.br = br; r.bt = bt; r.jmp = jmp; r.cl = cl; r.jt = jt;
    r.rt = rt; r.hl = hl; r.rs = rs; r.pc = epc; r.cnt = cnt; r.h = h; r.ov = ov; r.un = un;
    return r;
  endfunction
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask
  task automatic apply(vec_t r);
    reset = r.rst; enable = r.en; branch_taken = r.br; branch_target = 5'(r.bt);
    jump = r.jmp; call = r.cl; jump_target = 5'(r.jt); ret = r.rt; halt = r.hl; resume = r.rs;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(string tag, int idx, int epc, int cnt, bit h, bit ov, bit un);
    chk({tag, " pc"}, idx, 32'(pc), 32'(epc));
    chk({tag, " pc_plus"}, idx, 32'(pc_plus), 32'((epc + 1) % 32));
    chk({tag, " ras_count"}, idx, 32'(ras_count), 32'(cnt));
    chk({tag, " halted"}, idx, 32'(halted), 32'(h));
    chk({tag, " ras_overflow"}, idx, 32'(ras_overflow), 32'(ov));
    chk({tag, " ras_underflow"}, idx, 32'(ras_underflow), 32'(un));
  endtask
  int m_pc;
  bit m_h, m_ov, m_un;
  int m_ras[$];
  initial begin
    reset = 1'b0; enable = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0;
    ret = 1'b0; halt = 1'b0; resume = 1'b0; branch_target = '0; jump_target = '0;
    // reset, sequential advance, wrap
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,   0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   1,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   2,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   3,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,0,31,0,0,0,  31,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   0,0,0,0,0));
    // branch overrides stall, then stall holds
    tbl.push_back(v(0,0,0,0,1,0,4,0,0,0,   4,0,0,0,0));
    tbl.push_back(v(0,0,1,20,0,0,0,0,0,0,  20,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,   20,0,0,0,0));
    // nested call/return
    tbl.push_back(v(0,0,0,0,1,0,2,0,0,0,   2,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,10,0,0,0,  10,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,16,0,0,0,  16,2,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   11,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   3,0,0,0,0));
    // five calls overflow a 4-deep stack; oldest return (4) is lost
    tbl.push_back(v(0,0,0,0,0,1,8,0,0,0,   8,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,12,0,0,0,  12,2,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,16,0,0,0,  16,3,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,20,0,0,0,  20,4,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,24,0,0,0,  24,4,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   21,3,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   17,2,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   13,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   9,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,0,7,0,0,0,   7,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,0,0,   8,0,0,0,1));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   9,0,0,0,0));
    // halt ignores a simultaneous jump; HALTED ignores everything but resume
    tbl.push_back(v(0,0,0,0,1,0,6,0,0,0,   6,0,0,0,0));
    tbl.push_back(v(0,1,0,0,1,1,25,0,1,0,  6,0,1,0,0));
    tbl.push_back(v(0,1,1,3,1,1,25,1,0,0,  6,0,1,0,0));
    tbl.push_back(v(0,1,1,3,1,1,25,1,0,0,  6,0,1,0,0));
    tbl.push_back(v(0,1,1,3,1,1,25,1,0,0,  6,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,1,   6,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,1,   6,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   7,0,0,0,0));
    // call+ret together: ret wins, no push
    tbl.push_back(v(0,0,0,0,1,0,11,0,0,0,  11,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,20,0,0,0,  20,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,3,1,0,0,   12,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   13,0,0,0,0));
    // reset wins over a call, and over HALTED
    tbl.push_back(v(0,0,0,0,0,1,20,0,0,0,  20,1,0,0,0));
    tbl.push_back(v(1,0,0,0,0,1,9,0,0,0,   0,0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,   1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,0,   1,0,1,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,   0,0,0,0,0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      check_all("dir", i, tbl[i].pc, tbl[i].cnt, tbl[i].h, tbl[i].ov, tbl[i].un);
    end
    m_pc = 0; m_h = 0; m_ov = 0; m_un = 0; m_ras.delete();
    for (int n = 0; n < 2000; n++) begin
      vec_t r;
      r = v($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(3) == 0, int'($urandom_range(31)),
            $urandom_range(7) == 0, $urandom_range(4) == 0, int'($urandom_range(31)), $urandom_range(4) == 0,
            $urandom_range(9) == 0, $urandom_range(2) == 0, 0,0,0,0,0);
      m_ov = 0; m_un = 0;
      if (r.rst) begin
        m_pc = 0; m_h = 0; m_ras.delete();
      end else if (m_h) begin
        if (r.rs && !r.hl) m_h = 0;
      end else if (r.hl) begin
        m_h = 1;
      end else if (r.rt) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = (m_pc + 1) % 32; m_un = 1; end
      end else if (r.cl) begin
        if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_ov = 1; end
        m_ras.push_back((m_pc + 1) % 32);
        m_pc = r.jt;
      end else if (r.jmp) m_pc = r.jt;
      else if (r.br) m_pc = r.bt;
      else if (r.en) m_pc = (m_pc + 1) % 32;
      apply(r);
      check_all("rnd", n, m_pc, m_ras.size(), m_h, m_ov, m_un);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
